// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock, start/done handshake.
// Optional leading-zero blank mask is generated only when BCD_BLANK_EN is defined.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int BCD_W   = 4 * DIGITS;
    localparam int SCR_W   = BCD_W + BIN_W;
    localparam int CNT_W   = $clog2(BIN_W);
    localparam int LIMIT_W = BIN_W + 34;

    function automatic logic [LIMIT_W-1:0] pow10(input int n);
        logic [LIMIT_W-1:0] r;
        r = LIMIT_W'(1);
        for (int i = 0; i < n; i++) begin
            r = r * LIMIT_W'(10);
        end
        return r;
    endfunction

    localparam logic [LIMIT_W-1:0] MAX_VAL = pow10(DIGITS) - LIMIT_W'(1);
    // When 10^DIGITS exceeds 2^BIN_W no input can overflow, so the compare folds away.
    localparam bit OVF_POSSIBLE = (MAX_VAL < (LIMIT_W'(1) << BIN_W));
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   scratch_next;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;
    logic               ovf_check;
    logic               accept;
    logic               last_shift;

    // One double-dabble step: adjust every BCD column holding 5..9, then shift left.
    function automatic logic [SCR_W-1:0] dabble(input logic [SCR_W-1:0] s);
        logic [SCR_W-1:0] t;
        t = s;
        for (int d = 0; d < DIGITS; d++) begin
            if (t[BIN_W + 4*d +: 4] >= 4'd5) begin
                t[BIN_W + 4*d +: 4] = t[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
        return {t[SCR_W-2:0], 1'b0};
    endfunction

    assign scratch_next = dabble(scratch);
    assign ovf_check    = OVF_POSSIBLE ? (LIMIT_W'(bin_in) > MAX_VAL) : 1'b0;
    assign accept       = (state == IDLE) && start;
    assign last_shift   = (state == SHIFT) && (cnt == LAST_CNT);
    assign busy         = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                scratch  <= {{BCD_W{1'b0}}, bin_in};
                cnt      <= '0;
                ovf_pend <= ovf_check;
            end else if (state == SHIFT) begin
                scratch <= scratch_next;
                cnt     <= cnt + CNT_W'(1);
                if (last_shift) begin
                    bcd_out  <= ovf_pend ? {DIGITS{4'h9}} : scratch_next[SCR_W-1 -: BCD_W];
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                end
            end
        end
    end

`ifdef BCD_BLANK_EN
    // Digit i blanks when it and every more significant digit are zero; the ones digit always shows.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        blank    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero && (bcd_out[4*i +: 4] == 4'd0);
            blank[i] = all_zero;
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq (BIN_W=14, DIGITS=4): stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

`ifdef BCD_BLANK_EN
    localparam logic [3:0] BL_ZERO = 4'b1110;
    localparam logic [3:0] BL_7    = 4'b1110;
    localparam logic [3:0] BL_40   = 4'b1100;
`else
    localparam logic [3:0] BL_ZERO = 4'b0000;
    localparam logic [3:0] BL_7    = 4'b0000;
    localparam logic [3:0] BL_40   = 4'b0000;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic [BIN_W-1:0]  bin_in;
    logic              busy;
    logic              done;
    logic [15:0]       bcd_out;
    logic              overflow;
    logic [3:0]        blank;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow),
        .blank    (blank)
    );

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with bcd_out=%0h expected no done (cycle %0d)", bcd_out, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("bcd_out", 64'(bcd_out), 64'(e.bcd));
                check("overflow", 64'(overflow), 64'(e.ovf));
                check("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    // Called at a negedge: start is accepted at the next posedge, done visible BIN_W edges later.
    task automatic issue(input logic [BIN_W-1:0] v, input logic [15:0] bcd, input logic ovf, input bit expect_done);
        exp_t e;
        bin_in = v;
        start  = 1'b1;
        if (expect_done) begin
            e.bcd = bcd;
            e.ovf = ovf;
            e.cyc = cyc + 1 + BIN_W;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected %0d pending result(s)", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic convert(input logic [BIN_W-1:0] v, input logic [15:0] bcd, input logic ovf);
        @(negedge clk);
        issue(v, bcd, ovf, 1'b1);
        @(negedge clk);
        start  = 1'b0;
        bin_in = 14'h3fff;
        check("busy_after_start", 64'(busy), 64'd1);
        drain();
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_bcd", 64'(bcd_out), 64'h0000);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_blank", 64'(blank), 64'(BL_ZERO));

        convert(14'd2024, 16'h2024, 1'b0);
        check("blank_2024", 64'(blank), 64'h0);
        convert(14'd0, 16'h0000, 1'b0);
        check("blank_0", 64'(blank), 64'(BL_ZERO));
        convert(14'd9999, 16'h9999, 1'b0);
        convert(14'd12345, 16'h9999, 1'b1);
        convert(14'd3000, 16'h3000, 1'b0);
        convert(14'd16383, 16'h9999, 1'b1);
        convert(14'd10000, 16'h9999, 1'b1);

        // A start pulse mid-conversion must be dropped, not queued.
        @(negedge clk);
        issue(14'd2024, 16'h2024, 1'b0, 1'b1);
        @(negedge clk);
        start  = 1'b0;
        bin_in = 14'd777;
        repeat (3) @(negedge clk);
        bin_in = 14'd500;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (20) @(negedge clk);

        // Back-to-back: start held high, second accepted on the done cycle.
        @(negedge clk);
        begin
            int n;
            n = cyc;
            issue(14'd1999, 16'h1999, 1'b0, 1'b1);
            @(negedge clk);
            bin_in = 14'd2000;
            begin
                exp_t e;
                e.bcd = 16'h2000;
                e.ovf = 1'b0;
                e.cyc = n + 2 * (BIN_W + 1);
                q.push_back(e);
            end
            while (cyc < n + BIN_W + 2) @(negedge clk);
            start = 1'b0;
            check("busy_second", 64'(busy), 64'd1);
        end
        drain();
        repeat (20) @(negedge clk);

        // Reset in the middle of a conversion aborts it with no done.
        @(negedge clk);
        issue(14'd2024, 16'h2024, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_bcd", 64'(bcd_out), 64'h0000);
        check("abort_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("after_abort_busy", 64'(busy), 64'd0);

        convert(14'd7, 16'h0007, 1'b0);
        check("blank_7", 64'(blank), 64'(BL_7));
        convert(14'd40, 16'h0040, 1'b0);
        check("blank_40", 64'(blank), 64'(BL_40));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It replaces fixed-range combinational year decoders with one block covering any input width and digit count. It sits between the calendar/time counters and the seven-segment display drivers. Conversions are requested with a start/done handshake, and the result is held stable between conversions.

## Interface
- `BIN_W`, 14: binary input width; legal range 4..32.
- `DIGITS`, 4: number of BCD output digits; legal range 1..10.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: conversion request; sampled only in IDLE.
- `bin_in` input BIN_W: unsigned value; captured on the accepted start edge.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse when `bcd_out` and `overflow` update.
- `bcd_out` output 4*DIGITS: packed BCD; digit 0 (ones) is in [3:0]; held until the next `done`.
- `overflow` output 1: input exceeded 10^DIGITS−1; updates together with `done`.
- `blank` output DIGITS: leading-zero blank mask; see Configuration.

## Operation
- States: IDLE, SHIFT. There is no separate DONE state.
- IDLE to SHIFT on `start`=1:
  - Load the scratch register {4*DIGITS zeros, bin_in}.
  - Clear the bit counter to 0.
  - Set `ovf_pend` = (bin_in > 10^DIGITS−1). The constant is a localparam of width BIN_W+34. If 10^DIGITS > 2^BIN_W, `ovf_pend` is constant 0.
- Each SHIFT cycle:
  - Every 4-bit digit field of the scratch register that is ≥5 gets +3.
  - Then the whole scratch register shifts left by 1.
  - The counter increments.
- On the shift where counter == BIN_W−1:
  - `bcd_out` ← upper 4*DIGITS bits of the post-shift result, or all digits 9 if `ovf_pend`.
  - `overflow` ← `ovf_pend`.
  - `done` ← 1.
  - State returns to IDLE.
- `start` while in SHIFT is ignored and not queued. `bin_in` changes during SHIFT have no effect.
- `start` in the cycle `done` is high is accepted, because state is already IDLE.
- Every BCD digit of a non-overflow result lies in 0..9.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `bcd_out`=0, `overflow`=0, counter=0, scratch=0.
- Reset asserted mid-conversion aborts immediately. After reset, `done` does not pulse for the aborted request.
- `start` accepted at edge k:
  - `busy`=1 from edge k through edge k+BIN_W−1.
  - At edge k+BIN_W: `busy`=0, `done`=1, and outputs update.
  - Start-to-done latency is BIN_W cycles.
- `done` is high for exactly one cycle.
- Maximum throughput is one conversion per BIN_W+1 cycles (back-to-back start on the `done` cycle).
- `bcd_out` and `overflow` are registered; they never glitch between `done` pulses.

## Configuration
- Macro `BCD_BLANK_EN`:
  - Defined: `blank` is derived combinationally from `bcd_out`. `blank[i]`=1 when digit i and all higher digits are 0, for i ≥ 1. `blank[0]` is always 0.
  - Not defined: `blank` is tied to all zeros, and no blanking logic is generated.
- The port list is identical in both builds.

## Test plan
All scenarios use BIN_W=14, DIGITS=4.
- Reset, then idle: `busy`=0, `done`=0, `bcd_out`=16'h0000, `overflow`=0. With `BCD_BLANK_EN`, `blank`=4'b1110.
- `start` with `bin_in`=2024: `done` exactly 14 cycles later, `bcd_out`=16'h2024, `overflow`=0. Repeat for 0 → 16'h0000 and 9999 → 16'h9999.
- `bin_in`=12345: `overflow`=1, `bcd_out`=16'h9999. A following conversion of 3000 clears `overflow` to 0 and gives `bcd_out`=16'h3000.
- Pulse `start` with `bin_in`=500 at cycle 5 of a 2024 conversion: ignored. The result is 16'h2024, and only one `done` occurs.
- Back-to-back: hold `start` high continuously with values 1999 then 2000. Required: two `done` pulses 15 cycles apart, with results 16'h1999 then 16'h2000.
- Assert `rst` at cycle 7 of a conversion: outputs return to reset values immediately and no `done` follows. With `BCD_BLANK_EN`, converting 7 gives `blank`=4'b1110 and converting 40 gives 4'b1100.
